cdec8_seq: RTL

//  Microsequencer for the CDEC8 8-bit datapath. Drives the 15-bit control word {mmrw,fwr,rwr,xdst,aluop,xsrc}

---
 rtl/cdec8_seq.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/cdec8_seq.sv
// CDEC8 microsequencer: drives the 15-bit datapath control word from a fetch / operand /
// execute FSM, with run/single-step gating and a state code for the debug monitor.
module cdec8_seq #(
    parameter logic [4:0] ALU_THX = 5'h00,
    parameter logic [4:0] ALU_INC = 5'h01,
    parameter logic [4:0] ALU_ADD = 5'h08
) (
    input  logic        clock,
    input  logic        reset_N,
    input  logic [7:0]  I,
    input  logic [2:0]  SZCy,
    input  logic        run,
    input  logic        step,
    output logic [14:0] ctrl,
    output logic [7:0]  state,
    output logic        halted,
    output logic        illegal,
    output logic        inst_done
);
    typedef enum logic [4:0] {
        ST_RST  = 5'h00, ST_F0 = 5'h01, ST_F1 = 5'h02, ST_F2 = 5'h03, ST_F3 = 5'h04,
        ST_O0   = 5'h05, ST_O1 = 5'h06, ST_O2 = 5'h07,
        ST_E0   = 5'h08, ST_E1 = 5'h09, ST_E2 = 5'h0A,
        ST_WAIT = 5'h1E, ST_HALT = 5'h1F
    } state_t;

    localparam logic [2:0] XS_PC = 3'd0, XS_R = 3'd4, XS_RDR = 3'd5, XS_FF = 3'd7;
    localparam logic [2:0] XD_PC = 3'd0, XD_MAR = 3'd4, XD_WDR = 3'd5, XD_T = 3'd6, XD_I = 3'd7;
    localparam logic [1:0] MM_NONE = 2'b00, MM_RD = 2'b10, MM_WR = 2'b01;

    state_t     state_q, state_d, eff_st, fin_st;
    logic       illegal_q, illegal_d;
    logic       step_q, step_d;
    logic [1:0] mmrw;
    logic       fwr, rwr;
    logic [2:0] xdst, xsrc;
    logic [4:0] aluop;

    logic [3:0] op;
    logic [1:0] rd, rs;
    logic [2:0] rd_code, rs_code;
    logic [4:0] alu_rr;
    logic       needs_opnd, bad, cond, step_rise;

    always_comb begin
        op      = I[7:4];
        rd      = I[3:2];
        rs      = I[1:0];
        rd_code = 3'(rd) + 3'd1;
        rs_code = 3'(rs) + 3'd1;
        alu_rr  = ALU_ADD + 5'(op) - 5'd6;
        needs_opnd = (op == 4'h3) || (op == 4'h4) || (op == 4'h5) || (op == 4'hC) || (op == 4'hD);
        case (op)
            4'h2, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA: bad = (rd == 2'd3) || (rs == 2'd3);
            4'h3, 4'h4, 4'hB:                   bad = (rd == 2'd3);
            4'h5:                               bad = (rs == 2'd3);
            4'hE, 4'hF:                         bad = 1'b1;
            default:                            bad = 1'b0;
        endcase
        case (rs)
            2'd0:    cond = SZCy[1];
            2'd1:    cond = SZCy[0];
            2'd2:    cond = SZCy[2];
            default: cond = 1'b1;
        endcase
    end

    // I is only valid one cycle after F3, so F3 always moves to O0 and O0 turns into E0
    // for ops without an operand byte (or illegal ones); cycle counts match a decode at F3.
    assign eff_st    = (state_q == ST_O0 && (!needs_opnd || bad)) ? ST_E0 : state_q;
    assign fin_st    = run ? ST_F0 : ST_WAIT;
    assign step_rise = step & ~step_q;

    always_comb begin
        mmrw      = MM_NONE;
        fwr       = 1'b0;
        rwr       = 1'b0;
        xdst      = XD_T;
        aluop     = ALU_THX;
        xsrc      = XS_FF;
        state_d   = state_q;
        illegal_d = illegal_q;
        step_d    = step;
        inst_done = 1'b0;
        case (eff_st)
            ST_RST: state_d = ST_F0;
            ST_F0:  begin xdst = XD_MAR; xsrc = XS_PC; state_d = ST_F1; end
            ST_F1:  begin mmrw = MM_RD; xsrc = XS_PC; aluop = ALU_INC; rwr = 1'b1; state_d = ST_F2; end
            ST_F2:  begin xdst = XD_PC; xsrc = XS_R; state_d = ST_F3; end
            ST_F3:  begin xdst = XD_I; xsrc = XS_RDR; state_d = ST_O0; end
            ST_O0:  begin xdst = XD_MAR; xsrc = XS_PC; state_d = ST_O1; end
            ST_O1:  begin mmrw = MM_RD; xsrc = XS_PC; aluop = ALU_INC; rwr = 1'b1; state_d = ST_O2; end
            ST_O2:  begin xdst = XD_PC; xsrc = XS_R; state_d = ST_E0; end
            ST_E0: begin
                if (bad) begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALT;
                end else begin
                    inst_done = 1'b1;
                    state_d   = fin_st;
                    case (op)
                        4'h1: state_d = ST_HALT;
                        4'h2: begin xdst = rd_code; xsrc = rs_code; end
                        4'h3: begin xdst = rd_code; xsrc = XS_RDR; end
                        4'h4, 4'h5: begin
                            xdst = XD_MAR; xsrc = XS_RDR; inst_done = 1'b0; state_d = ST_E1;
                        end
                        4'h6, 4'h7, 4'h8, 4'h9, 4'hA: begin
                            xsrc = rs_code; inst_done = 1'b0; state_d = ST_E1;
                        end
                        4'hB: begin
                            xsrc = rd_code; aluop = ALU_INC; rwr = 1'b1; fwr = 1'b1;
                            inst_done = 1'b0; state_d = ST_E1;
                        end
                        4'hC: begin xdst = XD_PC; xsrc = XS_RDR; end
                        4'hD: if (cond) begin xdst = XD_PC; xsrc = XS_RDR; end
                        default: ;
                    endcase
                end
            end
            ST_E1: begin
                state_d = ST_E2;
                case (op)
                    4'h4: mmrw = MM_RD;
                    4'h5: begin xdst = XD_WDR; xsrc = rs_code; end
                    4'hB: begin xdst = rd_code; xsrc = XS_R; inst_done = 1'b1; state_d = fin_st; end
                    default: begin xsrc = rd_code; aluop = alu_rr; rwr = 1'b1; fwr = 1'b1; end
                endcase
            end
            ST_E2: begin
                inst_done = 1'b1;
                state_d   = fin_st;
                case (op)
                    4'h4:    begin xdst = rd_code; xsrc = XS_RDR; end
                    4'h5:    mmrw = MM_WR;
                    default: begin xdst = rd_code; xsrc = XS_R; end
                endcase
            end
            ST_WAIT: if (run || step_rise) state_d = ST_F0;
            ST_HALT: ;
            default: state_d = ST_RST;
        endcase
    end

    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            state_q   <= ST_RST;
            illegal_q <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            step_q    <= step_d;
        end
    end

    assign ctrl    = {mmrw, fwr, rwr, xdst, aluop, xsrc};
    assign state   = {3'b000, eff_st};
    assign halted  = (state_q == ST_HALT);
    assign illegal = illegal_q;
endmodule
